// File: rtl/usb_pio_pkg.sv
// Shared definitions for the USB PIO slaves: the register map and the bus width.
// Latency: n/a (constants only).
// Backpressure: n/a.
package usb_pio_pkg;

    localparam int DATA_BUS_W = 32;

    // Word addresses on the Avalon-MM slave
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // Warm-up counter value at which edge detection is trusted
    localparam logic [1:0] WARM_DONE = 2'd3;

endpackage

// File: rtl/usb_rd_sync.sv
// Two-flop synchronizer for WIDTH asynchronous lines, with an optional per-bit debounce filter.
// Latency: 2 clk to clean_o; plus DEBOUNCE_CYCLES clk when USB_RD_DEBOUNCE_EN is defined.
// Backpressure: none; free-running every clock.
//
// Ports: clk_i/reset_i (sync, active-high), async_i raw lines, clean_o synchronized/filtered bus.
// Build option: USB_RD_DEBOUNCE_EN enables the debounce filter.
module usb_rd_sync #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] clean_o
);

    // Reject out-of-range configurations at elaboration
    if (WIDTH < 1 || WIDTH > 32 || DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_param_check
        $error("usb_rd_sync: WIDTH must be 1..32 and DEBOUNCE_CYCLES 1..255");
    end

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef USB_RD_DEBOUNCE_EN
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [7:0]       cnt_q [WIDTH];
    logic [7:0]       cnt_d [WIDTH];
    logic [WIDTH-1:0] filt_q;
    logic [WIDTH-1:0] filt_d;

    // The counter only runs while sync2 disagrees with the filtered bit; any
    // return to agreement restarts it, so a flip needs an unbroken run.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                filt_d[i] = sync2_q[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            filt_q <= '0;
            cnt_q  <= '{default: '0};
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign clean_o = filt_q;
`else
    assign clean_o = sync2_q;
`endif

endmodule

// File: rtl/usb_rd.sv
// Avalon-MM input PIO for USB controller status lines: DATA, IRQMASK and sticky rising-edge capture with level IRQ.
// Latency: DATA 2 clk after an input change, EDGECAP/irq 3 clk (each +DEBOUNCE_CYCLES with USB_RD_DEBOUNCE_EN); readdata is combinational.
// Backpressure: none; zero-wait-state slave, writes take effect at the next clk edge.
//
// Ports: clk, reset (sync, active-high), address/chipselect/write_n/writedata (slave writes),
// readdata (combinational read mux), in_port (async lines), irq (active-high level).
// Build option: USB_RD_DEBOUNCE_EN inserts the debounce filter in usb_rd_sync.
module usb_rd
    import usb_pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [DATA_BUS_W-1:0] writedata,
    input  logic [WIDTH-1:0]      in_port,
    output logic [DATA_BUS_W-1:0] readdata,
    output logic                  irq
);

    logic [WIDTH-1:0] clean;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [1:0]       warm_q, warm_d;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] wdata;
    logic             wr_en;
    logic [DATA_BUS_W-1:0] unused_wdata;

    usb_rd_sync #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sync (
        .clk_i   (clk),
        .reset_i (reset),
        .async_i (in_port),
        .clean_o (clean)
    );

    // Only the low WIDTH bits of a write are meaningful
    assign unused_wdata = writedata;
    assign wdata        = writedata[WIDTH-1:0];
    assign wr_en        = chipselect & ~write_n;

    // Lines already high when reset releases must not look like edges, so
    // detection waits until the synchronizer and prev have real samples.
    assign rise = (warm_q == WARM_DONE) ? (clean & ~prev_q) : '0;

    always_comb begin
        warm_d    = (warm_q == WARM_DONE) ? warm_q : warm_q + 2'd1;
        irqmask_d = irqmask_q;
        edgecap_d = edgecap_q;
        if (wr_en && address == ADDR_IRQMASK) begin
            irqmask_d = wdata;
        end
        if (wr_en && address == ADDR_EDGECAP) begin
            edgecap_d = edgecap_q & ~wdata;
        end
        // OR in after the clear so a coincident edge survives its own W1C
        edgecap_d = edgecap_d | rise;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q    <= '0;
            edgecap_q <= '0;
            irqmask_q <= '0;
            warm_q    <= '0;
        end else begin
            prev_q    <= clean;
            edgecap_q <= edgecap_d;
            irqmask_q <= irqmask_d;
            warm_q    <= warm_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata = DATA_BUS_W'(clean);
            ADDR_IRQMASK: readdata = DATA_BUS_W'(irqmask_q);
            ADDR_EDGECAP: readdata = DATA_BUS_W'(edgecap_q);
            default:      readdata = '0;
        endcase
    end

    assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_usb_rd.sv
// Bench for usb_rd: directed steps followed by random traffic, all checked against a sample-history model.
// Latency: n/a.
// Backpressure: n/a.
module tb_usb_rd;
    import usb_pio_pkg::*;

    localparam int W  = 8;
    localparam int DC = 4;
`ifdef USB_RD_DEBOUNCE_EN
    localparam int LAT = 2 + DC;
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   readdata;
    logic          irq;

    int total = 0;
    int bad   = 0;

    usb_rd #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Reference state: samp[k-1] is in_port as sampled at the k-th edge after
    // reset release; cq[k-1] is the value DATA should show after that edge.
    logic [W-1:0] samp[$];
    logic [W-1:0] cq[$];
    logic [W-1:0] m_ecap;
    logic [W-1:0] m_mask;
`ifdef USB_RD_DEBOUNCE_EN
    logic [W-1:0] s2q[$];
    logic [W-1:0] f_m;

    function automatic logic [W-1:0] s2at(input int k);
        return (k >= 1) ? s2q[k-1] : '0;
    endfunction
`endif

    function automatic logic [W-1:0] cat(input int k);
        return (k >= 1) ? cq[k-1] : '0;
    endfunction

    function automatic logic [W-1:0] exp_data();
        return (cq.size() > 0) ? cq[cq.size()-1] : '0;
    endfunction

    task automatic tick();
        logic         we;
        logic [1:0]   a;
        logic [W-1:0] wd;
        logic [W-1:0] rise;
        logic [W-1:0] s2n;
        logic [W-1:0] cn;
        int           n;
        we = chipselect && !write_n;
        a  = address;
        wd = writedata[W-1:0];
        @(posedge clk);
        if (reset) begin
            samp.delete();
            cq.delete();
            m_ecap = '0;
            m_mask = '0;
`ifdef USB_RD_DEBOUNCE_EN
            s2q.delete();
            f_m = '0;
`endif
        end else begin
            samp.push_back(in_port);
            n   = samp.size();
            // Two register stages: the line sampled one edge ago is now visible
            s2n = (n >= 2) ? samp[n-2] : '0;
`ifdef USB_RD_DEBOUNCE_EN
            // A filtered bit flips once the last DC synchronized values all disagree with it
            for (int b = 0; b < W; b++) begin
                logic flip;
                logic [W-1:0] h;
                flip = 1'b1;
                for (int k = n - DC; k < n; k++) begin
                    h = s2at(k);
                    if (h[b] == f_m[b]) flip = 1'b0;
                end
                if (flip) f_m[b] = ~f_m[b];
            end
            s2q.push_back(s2n);
            cn = f_m;
`else
            cn = s2n;
`endif
            // A 0->1 in the clean stream is captured one edge later, but only
            // when both compared values were produced after warm-up (edge >= 3)
            rise = (n - 1 >= 3) ? (cat(n-1) & ~cat(n-2)) : '0;
            cq.push_back(cn);
            if (we && a == ADDR_EDGECAP) m_ecap = m_ecap & ~wd;
            m_ecap = m_ecap | rise;
            if (we && a == ADDR_IRQMASK) m_mask = wd;
        end
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic chk_all(input string t);
        logic [31:0] d;
        rd(ADDR_DATA, d);    chk({t, "_data"}, d, 32'(exp_data()));
        rd(2'd1, d);         chk({t, "_rsvd"}, d, 32'h0);
        rd(ADDR_IRQMASK, d); chk({t, "_mask"}, d, 32'(m_mask));
        rd(ADDR_EDGECAP, d); chk({t, "_ecap"}, d, 32'(m_ecap));
        chk({t, "_irq"}, {31'b0, irq}, {31'b0, |(m_ecap & m_mask)});
    endtask

    initial begin
        logic [31:0] d;
        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = '0;
        in_port    = 8'hFF;
        m_ecap     = '0;
        m_mask     = '0;
`ifdef USB_RD_DEBOUNCE_EN
        f_m        = '0;
`endif

        // Reset with all lines high
        tick(); tick();
        chk_all("in_reset");
        reset = 1'b0;
        repeat (5) tick();
        chk_all("post_reset5");
`ifndef USB_RD_DEBOUNCE_EN
        rd(ADDR_DATA, d);    chk("post_reset_data_ff", d, 32'h0000_00FF);
`endif
        repeat (8) tick();
        rd(ADDR_DATA, d);    chk("settled_data_ff", d, 32'h0000_00FF);
        rd(ADDR_EDGECAP, d); chk("no_edge_from_reset", d, 32'h0);

        // Falling edges do not capture
        in_port = 8'h00;
        repeat (10) tick();
        chk_all("fall_all");

        // 0x00 -> 0x05: DATA after two clocks, EDGECAP after three
        in_port = 8'h05;
        tick(); tick();
        chk_all("rise_t2");
        tick();
        chk_all("rise_t3");
        repeat (6) tick();
        rd(ADDR_EDGECAP, d); chk("ecap_05", d, 32'h05);
        chk("irq_masked_off", {31'b0, irq}, 32'h0);

        // Mask bit 2, then clear it via W1C
        wr(ADDR_IRQMASK, 32'h04);
        chk("irq_on_mask", {31'b0, irq}, 32'h1);
        wr(ADDR_EDGECAP, 32'h04);
        chk("irq_off_w1c", {31'b0, irq}, 32'h0);
        rd(ADDR_EDGECAP, d); chk("ecap_01", d, 32'h01);

        // New rise on bit 0 lands on the same edge as a W1C of bit 0
        in_port = 8'h04;
        repeat (10) tick();
        in_port = 8'h05;
        repeat (LAT) tick();
        wr(ADDR_EDGECAP, 32'h01);
        rd(ADDR_EDGECAP, d); chk("set_beats_clear", d, 32'h01);
        chk_all("set_beats_clear_m");
        wr(ADDR_EDGECAP, 32'h01);
        rd(ADDR_EDGECAP, d); chk("w1c_bit0", d, 32'h00);

        // 0x03 -> 0x00
        in_port = 8'h03;
        repeat (10) tick();
        wr(ADDR_EDGECAP, 32'hFF);
        in_port = 8'h00;
        repeat (10) tick();
        rd(ADDR_EDGECAP, d); chk("fall_ecap_0", d, 32'h0);
        rd(ADDR_DATA, d);    chk("fall_data_0", d, 32'h0);

        // Register-map corners
        wr(ADDR_IRQMASK, 32'hFFFF_FFFF);
        rd(ADDR_IRQMASK, d); chk("mask_upper_zero", d, 32'h0000_00FF);
        wr(ADDR_DATA, 32'h55);
        rd(ADDR_DATA, d);    chk("data_write_ignored", d, 32'h0);
        wr(2'd1, 32'h55);
        rd(2'd1, d);         chk("addr1_reads_0", d, 32'h0);
        wr(ADDR_IRQMASK, 32'h0);

`ifdef USB_RD_DEBOUNCE_EN
        // Glitch shorter than the filter window
        in_port = 8'h02;
        repeat (3) tick();
        in_port = 8'h00;
        repeat (10) tick();
        rd(ADDR_EDGECAP, d); chk("db_glitch_ecap", d, 32'h0);
        rd(ADDR_DATA, d);    chk("db_glitch_data", d, 32'h0);
        // Six-clock pulse: edge captured 2+DC+1 clocks after onset
        in_port = 8'h02;
        repeat (6) tick();
        rd(ADDR_EDGECAP, d); chk("db_pulse_t6", d, 32'h0);
        in_port = 8'h00;
        tick();
        rd(ADDR_EDGECAP, d); chk("db_pulse_t7", d, 32'h02);
        repeat (10) tick();
`endif

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 2) == 0) in_port = W'($urandom);
            case ($urandom_range(0, 5))
                0: begin chipselect = 1'b1; write_n = 1'b0; address = ADDR_IRQMASK; writedata = $urandom; end
                1: begin chipselect = 1'b1; write_n = 1'b0; address = ADDR_EDGECAP; writedata = $urandom; end
                2: begin chipselect = 1'b0; write_n = 1'b0; address = 2'($urandom); writedata = $urandom; end
                default: begin chipselect = 1'b0; write_n = 1'b1; end
            endcase
            tick();
            chipselect = 1'b0;
            write_n    = 1'b1;
            chk_all("rnd");
        end

        // Reset in the middle of activity, lines left high
        in_port = 8'hA5;
        wr(ADDR_IRQMASK, 32'hFF);
        reset = 1'b1;
        tick();
        chk_all("mid_reset");
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk_all("after_mid_reset");
        end
        rd(ADDR_EDGECAP, d); chk("mid_reset_no_edge", d, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usb_rd.md
Name: usb_rd

Overview:
- Avalon-MM slave input port. It is the read-side counterpart of the USB write-strobe output PIO.
- Samples external USB controller status/data lines (e.g. FIFO-not-empty, data byte) into the clk domain through a two-flop synchronizer.
- Captures rising edges per bit into a sticky register and raises a maskable interrupt to the Nios II CPU.
- Sits on the system interconnect beside the USB write PIO; software polls it or takes its IRQ.

Parameters:
- WIDTH, 8, number of input lines sampled (1..32).
- DEBOUNCE_CYCLES, 4, consecutive stable clocks required before a filtered value updates. Used only with USB_RD_DEBOUNCE_EN; range 1..255.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous external input lines.
- readdata  out  32  read data; zero-wait-state, combinational from address.
- irq  out  1  level interrupt, active-high.

Behaviour:
- Reset is synchronous and active-high. While reset is high at a clk edge, all of the following clear to 0: sync1, sync2, prev, edgecapture, irqmask, warm counter, debounce state. irq = 0 during and after reset.
- Register map (word addresses):
  - 0 DATA: read = zero-extended synchronized (or filtered) value; writes ignored.
  - 1: reads 0; writes ignored.
  - 2 IRQMASK: read/write, low WIDTH bits; upper bits read 0.
  - 3 EDGECAP: read = sticky rising-edge bits; write-1-to-clear per bit.
- Write decode: chipselect & ~write_n & address match, sampled at the clk edge. readdata is valid in the same cycle that address is presented; no read side effects.
- Synchronizer: sync1 <= in_port; sync2 <= sync1. A change on in_port set up before edge E1 is visible in DATA after edge E2.
- Edge detect: prev <= sync2 each cycle; rise = sync2 & ~prev. EDGECAP bit sets at E3, and irq asserts after E3 (combinational from registers).
- irq = |(edgecap & irqmask). It stays high until software clears the bits or masks them.
- Warm-up:
  - 2-bit warm counter increments from 0 after reset, saturating at 3.
  - rise is gated off until warm == 3. This prevents false edges from lines already high at reset release.
- Simultaneous events:
  - Rising edge and a W1C on the same bit in the same cycle: the set wins, and the bit stays 1.
  - W1C bits written 0 are unaffected.
- Falling edges are never captured.
- A pulse on in_port shorter than one clk period may be missed. That is acceptable and not flagged.
- Reset mid-operation: pending edges and mask are lost, and the warm-up restarts.

Optional Feature:
- Macro USB_RD_DEBOUNCE_EN.
- Defined:
  - Per-bit filter between sync2 and the DATA/edge logic.
  - An 8-bit counter per bit reloads on any sync2 change versus the filtered value.
  - filtered bit <= sync2 bit once sync2 differs from the filtered value and has held stable for DEBOUNCE_CYCLES consecutive clocks.
  - Adds DEBOUNCE_CYCLES clocks of latency to DATA and EDGECAP.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change and no edge.
- Undefined: filtered = sync2 directly; DEBOUNCE_CYCLES is ignored.

Decomposition:
- Shared package/include usb_pio_pkg:
  - register address constants (ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3);
  - DATA_BUS_W=32.
- Sub-module usb_rd_sync: parameterized WIDTH-bit two-flop synchronizer plus optional debounce filter. Its output is the clean bus.
- Register file, edge capture and irq logic stay in usb_rd.

Test Plan:
- Reset with in_port=8'hFF held high → after 5 clocks, DATA reads 0x000000FF, EDGECAP reads 0, irq=0.
- in_port 0x00→0x05 after warm-up → DATA=0x05 two clocks later; EDGECAP=0x05 three clocks later; irq stays 0 while IRQMASK=0.
- Write IRQMASK=0x04 with EDGECAP=0x05 → irq=1 next cycle. Write EDGECAP=0x04 → irq=0 and EDGECAP=0x01.
- Rising edge on bit 0 arriving in the same cycle as a W1C write of 0x01 → EDGECAP bit 0 remains 1.
- in_port 0x03→0x00 falling edge → EDGECAP unchanged; DATA=0x00.
- With USB_RD_DEBOUNCE_EN, DEBOUNCE_CYCLES=4:
  - 3-clock pulse on bit 1 → no DATA or EDGECAP change;
  - 6-clock pulse → EDGECAP bit 1 set 2+4+1 clocks after onset.
